// File: rtl/udp_cmd_parser.sv
// udp_cmd_parser: decodes fixed-format register commands from UDP payload.
// Accepts 8-bit AXI-Stream frames; issues write/read commands on cmd_*.
//
// Ports:
//   m_clk, m_rst_n       clock, async active-low reset
//   s_tdata/tvalid/...   payload stream in (tuser = bad frame, with tlast)
//   cmd_valid/ready      command handshake
//   cmd_write/addr/data  decoded command, stable while cmd_valid
//   err_pulse            one strobe per discarded frame
//   good_cnt, err_cnt    saturating frame counters
module udp_cmd_parser #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter logic [7:0] OP_WRITE  = 8'h01,
    parameter logic [7:0] OP_READ   = 8'h02,
    parameter int         CNT_WIDTH = 16
) (
    input  logic                 m_clk,
    input  logic                 m_rst_n,
    input  logic [7:0]           s_tdata,
    input  logic                 s_tvalid,
    output logic                 s_tready,
    input  logic                 s_tlast,
    input  logic                 s_tuser,
    output logic                 cmd_valid,
    input  logic                 cmd_ready,
    output logic                 cmd_write,
    output logic [7:0]           cmd_addr,
    output logic [31:0]          cmd_data,
    output logic                 err_pulse,
    output logic [CNT_WIDTH-1:0] good_cnt,
    output logic [CNT_WIDTH-1:0] err_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        OPCODE,
        ADDR,
        DATA,
        DROP,
        ISSUE
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t               r_state;
    state_t               w_nxt;
    logic                 r_tready;
    logic                 r_valid;
    logic                 r_write;
    logic [7:0]           r_addr;
    logic [31:0]          r_data;
    logic [1:0]           r_cnt;
    logic                 r_err_pulse;
    logic [CNT_WIDTH-1:0] r_good_cnt;
    logic [CNT_WIDTH-1:0] r_err_cnt;
    logic                 w_beat;
    logic                 w_err;
    logic                 w_op_ok;
    logic                 w_issue;

    assign w_beat  = s_tvalid & r_tready;
    assign w_op_ok = (s_tdata == OP_WRITE) || (s_tdata == OP_READ);
    assign w_issue = (w_nxt == ISSUE) && (r_state != ISSUE);

    // Next state and error detection. A tlast beat in a parsing state
    // either completes a good frame or ends in IDLE with an error; a
    // non-tlast error parks in DROP until the frame's tlast.
    always_comb begin
        w_nxt = r_state;
        w_err = 1'b0;
        if (w_beat) begin
            case (r_state)
                IDLE: begin
                    if (s_tlast) begin
                        w_err = 1'b1;
                    end else if (s_tdata == SYNC_BYTE) begin
                        w_nxt = OPCODE;
                    end else begin
                        w_err = 1'b1;
                        w_nxt = DROP;
                    end
                end
                OPCODE: begin
                    if (s_tlast) begin
                        w_err = 1'b1;
                        w_nxt = IDLE;
                    end else if (w_op_ok) begin
                        w_nxt = ADDR;
                    end else begin
                        w_err = 1'b1;
                        w_nxt = DROP;
                    end
                end
                ADDR: begin
                    if (s_tlast) begin
                        if (!s_tuser && !r_write) begin
                            w_nxt = ISSUE;
                        end else begin
                            w_err = 1'b1;
                            w_nxt = IDLE;
                        end
                    end else if (r_write) begin
                        w_nxt = DATA;
                    end else begin
                        w_err = 1'b1;
                        w_nxt = DROP;
                    end
                end
                DATA: begin
                    if (s_tlast) begin
                        if (!s_tuser && r_cnt == 2'd3) begin
                            w_nxt = ISSUE;
                        end else begin
                            w_err = 1'b1;
                            w_nxt = IDLE;
                        end
                    end else if (r_cnt == 2'd3) begin
                        w_err = 1'b1;
                        w_nxt = DROP;
                    end
                end
                DROP: begin
                    if (s_tlast) begin
                        w_nxt = IDLE;
                    end
                end
                default: begin
                    w_nxt = r_state;
                end
            endcase
        end
        if (r_state == ISSUE && cmd_ready) begin
            w_nxt = IDLE;
        end
    end

    always_ff @(posedge m_clk or negedge m_rst_n) begin
        if (!m_rst_n) begin
            r_state     <= IDLE;
            r_tready    <= 1'b0;
            r_valid     <= 1'b0;
            r_write     <= 1'b0;
            r_addr      <= 8'h00;
            r_data      <= 32'h0;
            r_cnt       <= 2'd0;
            r_err_pulse <= 1'b0;
            r_good_cnt  <= '0;
            r_err_cnt   <= '0;
        end else begin
            r_state     <= w_nxt;
            r_tready    <= (w_nxt != ISSUE);
            r_valid     <= (w_nxt == ISSUE);
            r_err_pulse <= w_err;
            if (w_beat) begin
                case (r_state)
                    OPCODE: begin
                        if (!s_tlast && w_op_ok) begin
                            r_write <= (s_tdata == OP_WRITE);
                            if (s_tdata == OP_READ) begin
                                r_data <= 32'h0;
                            end
                        end
                    end
                    ADDR: begin
                        r_addr <= s_tdata;
                        r_cnt  <= 2'd0;
                    end
                    DATA: begin
                        // Big-endian: first data byte ends up in [31:24].
                        r_data <= {r_data[23:0], s_tdata};
                        r_cnt  <= r_cnt + 2'd1;
                    end
                    default: begin
                        r_cnt <= r_cnt;
                    end
                endcase
            end
            if (w_issue && r_good_cnt != '1) begin
                r_good_cnt <= r_good_cnt + CNT_ONE;
            end
            if (w_err && r_err_cnt != '1) begin
                r_err_cnt <= r_err_cnt + CNT_ONE;
            end
        end
    end

    assign s_tready  = r_tready;
    assign cmd_valid = r_valid;
    assign cmd_write = r_write;
    assign cmd_addr  = r_addr;
    assign cmd_data  = r_data;
    assign err_pulse = r_err_pulse;
    assign good_cnt  = r_good_cnt;
    assign err_cnt   = r_err_cnt;

endmodule
